shaper_peak_detect: RTL and testbench

- Downstream consumer of the exponential signal generator output (output_data_exp_sig_gen) inside filter.
- Applies a moving-sum (box) shaping filter of length L = 2^WIN_LOG2 to the ADC-format stream.
- Runs a threshold-armed peak-detect FSM on the shaped stream and reports one peak value per pulse.
- Instantiated beside the v*_filter slots; it is the first stage to produce pulse amplitudes.

---
 rtl/shaper_peak_detect.sv | 143 ++++++++++++++
 tb/tb_shaper_peak_detect.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/shaper_peak_detect.sv
// Box (moving-sum) shaper over 2^WIN_LOG2 samples followed by a threshold-armed peak detector.
// Optional pileup re-arm during holdoff is enabled by defining SHAPER_PILEUP_DETECT_EN.
module shaper_peak_detect #(
  parameter int DATA_W           = 12,
  parameter int WIN_LOG2         = 3,
  parameter int SUM_W            = DATA_W + WIN_LOG2,
  parameter int SIZE_FILTER_DATA = 16,
  parameter int THRESHOLD        = 64,
  parameter int HOLDOFF          = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           input_data,
  output logic [SIZE_FILTER_DATA-1:0] output_data,
  output logic [SUM_W-1:0]            peak_value,
  output logic                        peak_valid,
  output logic                        pileup
);

  localparam int L     = 1 << WIN_LOG2;
  localparam int CNT_W = $clog2(HOLDOFF + 1);
  localparam logic [SUM_W-1:0] TH        = SUM_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RISING  = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  logic [DATA_W-1:0] r_x;
  logic [DATA_W-1:0] r_dly [L];
  logic [SUM_W-1:0]  r_sum;
  logic [SUM_W:0]    w_sum_wide;

  state_t            r_state, w_state_nx;
  logic [SUM_W-1:0]  r_peak_reg, w_peak_reg_nx;
  logic [SUM_W-1:0]  r_peak_value, w_peak_value_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
  logic              r_peak_valid, w_peak_valid_nx;
  logic              r_pileup, w_pileup_nx;
  logic              w_rise;

  // Sum never goes negative: the subtracted sample is always already inside it.
  assign w_sum_wide = {1'b0, r_sum}
                    + {{(SUM_W + 1 - DATA_W){1'b0}}, r_x}
                    - {{(SUM_W + 1 - DATA_W){1'b0}}, r_dly[L-1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x   <= '0;
      r_sum <= '0;
      for (int i = 0; i < L; i++) r_dly[i] <= '0;
    end else begin
      r_x      <= input_data;
      r_dly[0] <= r_x;
      for (int i = 1; i < L; i++) r_dly[i] <= r_dly[i-1];
      r_sum    <= w_sum_wide[SUM_W-1:0];
    end
  end

`ifdef SHAPER_PILEUP_DETECT_EN
  logic [SUM_W-1:0] r_sum_d1, r_sum_d2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum_d1 <= '0;
      r_sum_d2 <= '0;
    end else begin
      r_sum_d1 <= r_sum;
      r_sum_d2 <= r_sum_d1;
    end
  end

  assign w_rise = (r_sum > r_sum_d1) && (r_sum_d1 > r_sum_d2);
`else
  assign w_rise = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_peak_reg   <= '0;
      r_peak_value <= '0;
      r_cnt        <= '0;
      r_peak_valid <= 1'b0;
      r_pileup     <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_peak_reg   <= w_peak_reg_nx;
      r_peak_value <= w_peak_value_nx;
      r_cnt        <= w_cnt_nx;
      r_peak_valid <= w_peak_valid_nx;
      r_pileup     <= w_pileup_nx;
    end
  end

  always_comb begin
    w_state_nx      = r_state;
    w_peak_reg_nx   = r_peak_reg;
    w_peak_value_nx = r_peak_value;
    w_cnt_nx        = r_cnt;
    w_peak_valid_nx = 1'b0;
    w_pileup_nx     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_sum > TH) begin
          w_peak_reg_nx = r_sum;
          w_state_nx    = S_RISING;
        end
      end
      S_RISING: begin
        if (r_sum >= r_peak_reg) begin
          w_peak_reg_nx = r_sum;
        end else begin
          w_peak_value_nx = r_peak_reg;
          w_peak_valid_nx = 1'b1;
          w_cnt_nx        = HOLD_INIT;
          w_state_nx      = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (w_rise) begin
          w_pileup_nx   = 1'b1;
          w_peak_reg_nx = r_sum;
          w_state_nx    = S_RISING;
        end else if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end else if (r_sum <= TH) begin
          // Re-arm only once the shaped signal has dropped back to threshold.
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign output_data = SIZE_FILTER_DATA'(r_sum);
  assign peak_value  = r_peak_value;
  assign peak_valid  = r_peak_valid;
  assign pileup      = r_pileup;

endmodule

// File: tb/tb_shaper_peak_detect.sv
// Directed bench for shaper_peak_detect; expectations are hand-derived for L=8, THRESHOLD=64, HOLDOFF=16.
// Pileup expectations follow SHAPER_PILEUP_DETECT_EN when it is defined for the build.
module tb_shaper_peak_detect;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] input_data;
  logic [15:0] output_data;
  logic [14:0] peak_value;
  logic        peak_valid;
  logic        pileup;

  int n_tests = 0;
  int n_fail  = 0;

  int          s_first_valid, s_valid_cnt, s_pile_cnt, s_plat_cnt;
  logic [31:0] s_max_out, s_last_peak, s_out_before, s_prev_out;

  shaper_peak_detect dut (
    .clk         (clk),
    .reset       (reset),
    .input_data  (input_data),
    .output_data (output_data),
    .peak_value  (peak_value),
    .peak_valid  (peak_valid),
    .pileup      (pileup)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    s_first_valid = -1;
    s_valid_cnt   = 0;
    s_pile_cnt    = 0;
    s_plat_cnt    = 0;
    s_max_out     = 0;
    s_last_peak   = 0;
    s_out_before  = 0;
    s_prev_out    = 32'(output_data);
  endtask

  task automatic record(input int idx, input int plat);
    if (32'(output_data) > s_max_out) s_max_out = 32'(output_data);
    if (32'(output_data) == 32'(plat)) s_plat_cnt++;
    if (peak_valid) begin
      s_valid_cnt++;
      if (s_first_valid < 0) s_first_valid = idx;
      s_last_peak  = 32'(peak_value);
      s_out_before = s_prev_out;
    end
    if (pileup) s_pile_cnt++;
    s_prev_out = 32'(output_data);
  endtask

  task automatic run_pulse(input int value, input int len, input int ncyc, input int plat);
    clear_stats();
    for (int i = 0; i < ncyc; i++) begin
      input_data = (i < len) ? 12'(value) : 12'd0;
      step();
      record(i, plat);
    end
    input_data = 12'd0;
  endtask

  task automatic idle(input int n);
    input_data = 12'd0;
    for (int i = 0; i < n; i++) step();
  endtask

  int second_start;

  initial begin
    reset      = 1'b1;
    input_data = 12'd0;
    step();
    step();
    chk("rst_out",   32'(output_data), 0);
    chk("rst_peak",  32'(peak_value),  0);
    chk("rst_valid", 32'(peak_valid),  0);
    chk("rst_pile",  32'(pileup),      0);
    reset = 1'b0;

    // all-zero input
    run_pulse(0, 0, 100, 1);
    chk("zero_max_out", s_max_out, 0);
    chk("zero_valid",   32'(s_valid_cnt), 0);

    // single impulse of 200
    run_pulse(200, 1, 30, 200);
    chk("imp_plateau",    32'(s_plat_cnt), 8);
    chk("imp_max_out",    s_max_out, 200);
    chk("imp_valid_cnt",  32'(s_valid_cnt), 1);
    chk("imp_valid_idx",  32'(s_first_valid), 10);
    chk("imp_peak",       s_last_peak, 200);
    chk("imp_out_before", s_out_before, 0);
    idle(20);

    // single impulse at/below threshold
    run_pulse(60, 1, 40, 60);
    chk("sub_plateau",  32'(s_plat_cnt), 8);
    chk("sub_valid",    32'(s_valid_cnt), 0);
    idle(10);

    // step of 100 for 20 samples
    run_pulse(100, 20, 50, 800);
    chk("step_max_out",    s_max_out, 800);
    chk("step_plateau",    32'(s_plat_cnt), 13);
    chk("step_valid_cnt",  32'(s_valid_cnt), 1);
    chk("step_valid_idx",  32'(s_first_valid), 22);
    chk("step_peak",       s_last_peak, 800);
    chk("step_out_before", s_out_before, 700);
    idle(20);

    // two step pulses, second begins 5 cycles after the first peak strobe
    clear_stats();
    second_start = 1000;
    for (int i = 0; i < 120; i++) begin
      input_data = ((i < 20) || (i >= second_start && i < second_start + 20)) ? 12'd100 : 12'd0;
      step();
      record(i, 800);
      if (peak_valid && second_start == 1000) second_start = i + 5;
    end
    input_data = 12'd0;
    chk("dbl_first_idx", 32'(s_first_valid), 22);
`ifdef SHAPER_PILEUP_DETECT_EN
    chk("dbl_valid_cnt", 32'(s_valid_cnt), 2);
    chk("dbl_pile_cnt",  32'(s_pile_cnt), 1);
    chk("dbl_peak",      s_last_peak, 800);
`else
    chk("dbl_valid_cnt", 32'(s_valid_cnt), 1);
    chk("dbl_pile_cnt",  32'(s_pile_cnt), 0);
    chk("dbl_peak",      32'(peak_value), 800);
`endif
    idle(20);

    // full scale input, no wrap
    run_pulse(4095, 10, 40, 32760);
    chk("fs_max_out",   s_max_out, 32760);
    chk("fs_valid_cnt", 32'(s_valid_cnt), 1);
    chk("fs_peak",      s_last_peak, 32760);
    idle(20);

    // asynchronous reset in the middle of a rising pulse
    input_data = 12'd100;
    for (int i = 0; i < 5; i++) step();
    chk("mid_sum", 32'(output_data), 400);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_out",   32'(output_data), 0);
    chk("mid_rst_peak",  32'(peak_value),  0);
    chk("mid_rst_valid", 32'(peak_valid),  0);
    chk("mid_rst_pile",  32'(pileup),      0);
    input_data = 12'd0;
    #3 reset = 1'b0;
    run_pulse(0, 0, 40, 1);
    chk("post_rst_valid", 32'(s_valid_cnt), 0);
    chk("post_rst_max",   s_max_out, 0);
    run_pulse(200, 1, 30, 200);
    chk("post_rst_imp_cnt",  32'(s_valid_cnt), 1);
    chk("post_rst_imp_idx",  32'(s_first_valid), 10);
    chk("post_rst_imp_peak", s_last_peak, 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
